// File: rtl/lsu_m.sv
// Load/store unit for the M stage: issues one bus access per memory op, aligns
// store data, extends load data and holds the pipeline until the access drains.
module lsu_m (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 2'd0;
            4'd3, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd1:    return lo[0];
            2'd2:    return lo != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_wstrb(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            4'd6:    return 4'b0001 << lo;
            4'd7:    return lo[1] ? 4'b1100 : 4'b0011;
            4'd8:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Selects the addressed lane of the raw word and sign/zero extends it.
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] lo,
                                             input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[8*lo +: 8];
        h = lo[1] ? raw[31:16] : raw[15:0];
        case (op)
            4'd1:    return {{24{b[7]}}, b};
            4'd2:    return {24'd0, b};
            4'd3:    return {{16{h[15]}}, h};
            4'd4:    return {16'd0, h};
            4'd5:    return raw;
            default: return 32'd0;
        endcase
    endfunction

    state_t      state_r;
    logic [3:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic [1:0]  size_r;
    logic        wr_r;
    logic        discard_r;
    logic [31:0] cap_r;

    logic        load_s;
    logic        store_s;
    logic [1:0]  size_s;
    logic        mis_s;
    logic        issue_s;
    logic        discard_s;
    logic [31:0] ext_s;

    // Decode of the op currently sitting in M.
    always_comb begin
        load_s    = is_load(mem_op_i);
        store_s   = is_store(mem_op_i);
        size_s    = op_size(mem_op_i);
        mis_s     = valid_i & (load_s | store_s) & misaligned(size_s, addr_i[1:0]);
        issue_s   = (state_r == IDLE) & valid_i & (load_s | store_s) & ~mis_s & ~flush_i & ~rst;
        discard_s = discard_r | flush_i;
        ext_s     = load_ext(op_r, addr_r[1:0], data_rdata);
    end

    // Bus request, stall and result outputs; IDLE drives the live op so a request goes out the same cycle.
    always_comb begin
        data_req   = 1'b0;
        data_wr    = wr_r;
        data_size  = size_r;
        data_addr  = addr_r;
        data_wdata = wdata_r;
        data_wstrb = wstrb_r;
        stall_o    = 1'b0;
        rdata_o    = 32'd0;
        if (rst) begin
            stall_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        data_req   = 1'b1;
                        data_wr    = store_s;
                        data_size  = size_s;
                        data_addr  = addr_i;
                        data_wdata = lane_wdata(size_s, wdata_i);
                        data_wstrb = lane_wstrb(mem_op_i, addr_i[1:0]);
                        stall_o    = 1'b1;
                    end else begin
                        stall_o = 1'b0;
                    end
                end
                REQ: begin
                    data_req = 1'b1;
                    stall_o  = 1'b1;
                end
                WAIT: begin
                    stall_o = ~data_data_ok;
                    if (data_data_ok && !discard_s) begin
                        rdata_o = ext_s;
                    end else begin
                        rdata_o = 32'd0;
                    end
                end
                HOLD: rdata_o = cap_r;
                default: stall_o = 1'b0;
            endcase
        end
        adel_o     = ~rst & mis_s & load_s;
        ades_o     = ~rst & mis_s & store_s;
        badvaddr_o = (adel_o | ades_o) ? addr_i : 32'd0;
    end

    // Access FSM; a flush after issue only marks the access so it drains without a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            op_r      <= 4'd0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            size_r    <= 2'd0;
            wr_r      <= 1'b0;
            discard_r <= 1'b0;
            cap_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        op_r      <= mem_op_i;
                        addr_r    <= addr_i;
                        wdata_r   <= lane_wdata(size_s, wdata_i);
                        wstrb_r   <= lane_wstrb(mem_op_i, addr_i[1:0]);
                        size_r    <= size_s;
                        wr_r      <= store_s;
                        discard_r <= 1'b0;
                        state_r   <= data_addr_ok ? WAIT : REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                    if (data_addr_ok) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT: begin
                    if (data_data_ok) begin
                        discard_r <= 1'b0;
                        if (discard_s) begin
                            cap_r   <= 32'd0;
                            state_r <= IDLE;
                        end else begin
                            cap_r   <= ext_s;
                            state_r <= stall_i ? HOLD : IDLE;
                        end
                    end else if (flush_i) begin
                        discard_r <= 1'b1;
                    end else begin
                        discard_r <= discard_r;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_m.sv
// Randomized scoreboard bench for lsu_m: a bus-slave driver issues ops and queues
// expected requests/results; a negedge monitor compares them as the DUT presents them.
module tb_lsu_m;
    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, stall_i;
    logic [3:0]  mem_op_i;
    logic [31:0] addr_i, wdata_i;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, rdata_o;
    logic        stall_o, adel_o, ades_o;
    logic [31:0] badvaddr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        req_q[$];
    logic [31:0] rsp_q[$];
    req_t        mon_e;
    logic [31:0] mon_r;

    lsu_m dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .stall_i(stall_i), .data_req(data_req),
        .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .rdata_o(rdata_o),
        .stall_o(stall_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the op/address rules.
    function automatic bit m_load(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd5;
    endfunction
    function automatic bit m_store(input logic [3:0] op);
        return op >= 4'd6 && op <= 4'd8;
    endfunction
    function automatic int m_bytes(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
        return 4;
    endfunction
    function automatic logic [31:0] m_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        if (m_bytes(op) == 1) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (op == 4'd1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (m_bytes(op) == 2) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (op == 4'd3 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return m_load(op) ? v : 32'd0;
    endfunction
    function automatic req_t m_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        req_t r;
        r.wr   = m_store(op);
        r.size = (m_bytes(op) == 1) ? 2'd0 : (m_bytes(op) == 2) ? 2'd1 : 2'd2;
        r.addr = a;
        if (!m_store(op))            begin r.wstrb = 4'd0; r.wdata = 32'd0; end
        else if (m_bytes(op) == 1)   begin r.wstrb = 4'(1 << (a % 4)); r.wdata = (wd & 32'hFF) * 32'h0101_0101; end
        else if (m_bytes(op) == 2)   begin r.wstrb = ((a / 2) % 2 == 1) ? 4'd12 : 4'd3; r.wdata = (wd & 32'hFFFF) * 32'h0001_0001; end
        else                         begin r.wstrb = 4'd15; r.wdata = wd; end
        return r;
    endfunction

    // Monitor: compares accepted requests and returned results against the queues.
    always @(negedge clk) begin
        if (!rst && data_req && data_addr_ok) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = req_q.pop_front();
                chk("req_addr", data_addr, mon_e.addr);
                chk("req_wr", {31'd0, data_wr}, {31'd0, mon_e.wr});
                chk("req_size", {30'd0, data_size}, {30'd0, mon_e.size});
                chk("req_wstrb", {28'd0, data_wstrb}, {28'd0, mon_e.wstrb});
                if (mon_e.wr) chk("req_wdata", data_wdata, mon_e.wdata);
            end
        end
        if (!rst && data_data_ok && rsp_q.size() > 0) begin
            mon_r = rsp_q.pop_front();
            chk("rdata_bypass", rdata_o, mon_r);
            chk("stall_at_data_ok", {31'd0, stall_o}, 32'd0);
        end
    end

    // Issues one op and plays bus slave. fl_cyc: cycle of a one-cycle flush (-1 none);
    // hold_n: cycles of stall_i from the data_ok cycle on.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int a_dly, input int d_dly,
                          input int fl_cyc, input int hold_n);
        bit          mem, bad, disc;
        int          done_c, n_req, n_stall;
        logic [31:0] exp_r;
        req_t        e;
        mem    = m_load(op) || m_store(op);
        bad    = mem && (a % m_bytes(op)) != 0;
        done_c = a_dly + 1 + d_dly;
        disc   = fl_cyc >= 1 && fl_cyc <= done_c;
        exp_r  = disc ? 32'd0 : m_result(op, a, rd);
        e      = m_req(op, a, wd);
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = op; addr_i = a; wdata_i = wd;
        if (!mem || bad || fl_cyc == 0) begin
            flush_i = (fl_cyc == 0);
            data_addr_ok = 1'($urandom);
            @(negedge clk);
            chk("adel", {31'd0, adel_o}, {31'd0, bad && m_load(op)});
            chk("ades", {31'd0, ades_o}, {31'd0, bad && m_store(op)});
            chk("badvaddr", badvaddr_o, bad ? a : 32'd0);
            chk("no_req", {31'd0, data_req}, 32'd0);
            chk("no_stall", {31'd0, stall_o}, 32'd0);
        end else begin
            req_q.push_back(e);
            rsp_q.push_back(exp_r);
            n_req = 0; n_stall = 0;
            for (int c = 0; c <= done_c + hold_n; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                flush_i      = (c == fl_cyc);
                data_addr_ok = (c == a_dly);
                data_data_ok = (c == done_c);
                data_rdata   = (c == done_c) ? rd : $urandom;
                stall_i      = (hold_n > 0) && (c >= done_c) && (c < done_c + hold_n);
                if (disc && c > done_c) valid_i = 1'b0;
                @(negedge clk);
                if (data_req) n_req++;
                if (stall_o) n_stall++;
                if (data_req && c > 0) chk("req_stable_addr", data_addr, a);
                if (c > done_c) begin
                    chk("hold_rdata", rdata_o, exp_r);
                    chk("hold_stall", {31'd0, stall_o}, 32'd0);
                end
            end
            chk("req_cycles", n_req, a_dly + 1);
            chk("stall_cycles", n_stall, done_c);
        end
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        int          ad, dd, fl;
        rst = 1'b1; valid_i = 1'b1; mem_op_i = 4'd1; addr_i = 32'h10; wdata_i = 32'd0;
        flush_i = 1'b0; stall_i = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'd0;
        @(negedge clk);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
        mem_op_i = 4'd5; addr_i = 32'h3001;
        @(negedge clk);
        chk("rst_adel", {31'd0, adel_o}, 32'd0);
        chk("rst_ades", {31'd0, ades_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; data_addr_ok = 1'b0;

        // Directed corner cases.
        run_op(4'd1, 32'h1003, 32'd0, 32'h80FF_FF00, 0, 0, -1, 0);
        run_op(4'd7, 32'h2002, 32'h1234_ABCD, 32'd0, 0, 0, -1, 0);
        run_op(4'd5, 32'h3001, 32'd0, 32'd0, 0, 0, -1, 0);
        run_op(4'd8, 32'h3001, 32'h5555_AAAA, 32'd0, 0, 0, -1, 0);
        run_op(4'd5, 32'h4000, 32'd0, 32'hCAFE_F00D, 3, 0, -1, 2);
        run_op(4'd5, 32'h5004, 32'd0, 32'h1357_9BDF, 0, 2, 1, 1);
        run_op(4'd3, 32'h6002, 32'd0, 32'h8001_0000, 2, 1, 1, 0);
        run_op(4'd6, 32'h7001, 32'h0000_00A5, 32'd0, 0, 0, 0, 0);

        // Abandon an access with reset; the late data_ok must be ignored.
        @(posedge clk); #1;
        valid_i = 1'b1; mem_op_i = 4'd5; addr_i = 32'h40; data_addr_ok = 1'b1;
        req_q.push_back(m_req(4'd5, 32'h40, 32'd0));
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'd0, data_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("late_ok_stall", {31'd0, stall_o}, 32'd0);
        chk("late_ok_rdata", rdata_o, 32'd0);
        @(posedge clk); #1;
        data_data_ok = 1'b0;

        // Randomized ops.
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 10));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((m_bytes(op) == 4) ? 32'd3 : (m_bytes(op) == 2) ? 32'd1 : 32'd0);
            ad = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ad + 1 + dd)) : -1;
            run_op(op, a, $urandom, $urandom, ad, dd, fl, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        repeat (2) @(posedge clk);
        chk("req_q_empty", req_q.size(), 32'd0);
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
